// File: rtl/nx_stream_pkg.sv
// Shared widths, strobe codes and packer state type for the host-to-device stream packer.
package nx_stream_pkg;

    localparam int MSG_WIDTH     = 31;
    localparam int WORD_WIDTH    = 32;
    localparam int CTRL_FLAG_BIT = 31;

    localparam logic [7:0] STRB_FULL = 8'hFF;
    localparam logic [7:0] STRB_LOW  = 8'h0F;

    typedef enum logic {
        PACK_EMPTY,
        PACK_HELD
    } pack_state_t;

    // Tag a payload with its source: bit 31 set for control, clear for mesh.
    function automatic logic [WORD_WIDTH-1:0] make_word(input logic                 is_ctrl,
                                                        input logic [MSG_WIDTH-1:0] payload);
        logic [WORD_WIDTH-1:0] word;
        word                = '0;
        word[MSG_WIDTH-1:0] = payload;
        word[CTRL_FLAG_BIT] = is_ctrl;
        return word;
    endfunction

endpackage

// File: rtl/nx_rr_arb2.sv
// Two-way round-robin arbiter; priority flips only when a grant is actually consumed.
module nx_rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    logic r_last_hi;  // 1 when req[1] was granted most recently

    always_comb begin
        // NOTE: assign every output a default first so no path leaves it unassigned (no latch).
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt = r_last_hi ? 2'b01 : 2'b10;
        end else begin
            o_gnt = i_req;
        end
    end

    // Reset value makes req[0] (control) win the first contested cycle.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rstn) begin
            r_last_hi <= 1'b1;
        end else if (i_accept) begin
            r_last_hi <= o_gnt[1];
        end
    end

endmodule

// File: rtl/nx_stream_packer.sv
// Packs tagged control/mesh words two per 64-bit AXI4-stream beat; a lone word is
// flushed as a half beat once it has waited FLUSH_CYCLES idle cycles.
module nx_stream_packer
    import nx_stream_pkg::*;
#(
    parameter int AXI4_DATA_WIDTH = 64,
    parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8,
    parameter int AXI4_ID_WIDTH   = 1,
    parameter int FLUSH_CYCLES    = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [MSG_WIDTH-1:0]       ctrl_data,
    input  logic                       ctrl_valid,
    output logic                       ctrl_ready,
    input  logic [MSG_WIDTH-1:0]       mesh_data,
    input  logic                       mesh_valid,
    output logic                       mesh_ready,
    output logic [AXI4_DATA_WIDTH-1:0] outbound_tdata,
    output logic [AXI4_STRB_WIDTH-1:0] outbound_tkeep,
    output logic [AXI4_STRB_WIDTH-1:0] outbound_tstrb,
    output logic [AXI4_ID_WIDTH-1:0]   outbound_tid,
    output logic                       outbound_tlast,
    output logic                       outbound_tvalid,
    input  logic                       outbound_tready
);

    localparam int                    CNT_WIDTH = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] FLUSH_MAX = CNT_WIDTH'(FLUSH_CYCLES);

    pack_state_t                r_state;
    pack_state_t                w_next_state;
    logic [WORD_WIDTH-1:0]      r_low_word;
    logic [CNT_WIDTH-1:0]       r_flush_cnt;
    logic [AXI4_DATA_WIDTH-1:0] r_tdata;
    logic [AXI4_STRB_WIDTH-1:0] r_tstrb;
    logic                       r_tvalid;

    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_out_free;
    logic                  w_can_accept;
    logic                  w_accept;
    logic                  w_load_full;
    logic                  w_load_half;
    logic [WORD_WIDTH-1:0] w_new_word;

    assign w_out_free = !r_tvalid || outbound_tready;
    assign w_req      = {mesh_valid, ctrl_valid};
    assign w_new_word = w_gnt[0] ? make_word(1'b1, ctrl_data) : make_word(1'b0, mesh_data);

    nx_rr_arb2 u_arb (
        .clk      (clk),
        .rstn     (rstn),
        .i_req    (w_req),
        .i_accept (w_accept),
        .o_gnt    (w_gnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= PACK_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            PACK_EMPTY: if (w_accept) w_next_state = PACK_HELD;
            PACK_HELD:  if (w_load_full || w_load_half) w_next_state = PACK_EMPTY;
            default:    w_next_state = PACK_EMPTY;
        endcase
    end

    // A waiting partner always beats the timeout, so a half beat needs no request at all.
    always_comb begin
        w_can_accept = 1'b0;
        w_load_full  = 1'b0;
        w_load_half  = 1'b0;
        case (r_state)
            PACK_EMPTY: w_can_accept = 1'b1;
            PACK_HELD: begin
                w_can_accept = w_out_free;
                w_load_full  = w_out_free && (w_req != 2'b00);
                w_load_half  = w_out_free && (w_req == 2'b00) && (r_flush_cnt == FLUSH_MAX);
            end
            default: w_can_accept = 1'b0;
        endcase
        w_accept = w_can_accept && (w_gnt != 2'b00);
    end

    assign ctrl_ready = w_gnt[0] && w_can_accept;
    assign mesh_ready = w_gnt[1] && w_can_accept;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_low_word  <= '0;
            r_flush_cnt <= '0;
        end else if (r_state == PACK_EMPTY) begin
            if (w_accept) begin
                r_low_word  <= w_new_word;
                r_flush_cnt <= '0;
            end
        end else if (!w_load_full && !w_load_half && (r_flush_cnt != FLUSH_MAX)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // Output register reloads on the popping edge, so back-to-back beats have no bubble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tstrb  <= '0;
        end else if (w_load_full) begin
            r_tvalid <= 1'b1;
            r_tdata  <= {w_new_word, r_low_word};
            r_tstrb  <= STRB_FULL;
        end else if (w_load_half) begin
            r_tvalid <= 1'b1;
            r_tdata  <= {{WORD_WIDTH{1'b0}}, r_low_word};
            r_tstrb  <= STRB_LOW;
        end else if (outbound_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign outbound_tdata  = r_tdata;
    assign outbound_tstrb  = r_tstrb;
    assign outbound_tkeep  = r_tstrb;
    assign outbound_tid    = '0;
    assign outbound_tlast  = 1'b1;
    assign outbound_tvalid = r_tvalid;

endmodule
